// File: rtl/uart_apb_regs.sv
// APB3 register bank for the user side of a FIFO-buffered UART.
// It pushes TX bytes, pops RX bytes, holds the baud prescale and drives a level interrupt.
module uart_apb_regs #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter logic [15:0] PRESCALE_RESET = 16'd54,
  parameter int unsigned TIMEOUT        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [3:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] tx_data_in,
  output logic                  tx_valid_in,
  input  logic                  tx_ready_out,
  input  logic [DATA_WIDTH-1:0] rx_data_out,
  input  logic                  rx_valid_out,
  output logic                  rx_ready_in,
  output logic [15:0]           prescale,
  output logic                  irq
);
  localparam logic [1:0] A_DATA     = 2'd0;
  localparam logic [1:0] A_STATUS   = 2'd1;
  localparam logic [1:0] A_PRESCALE = 2'd2;
  localparam logic [7:0] WCNT_MAX   = 8'(TIMEOUT);

  logic       acc;
  logic [1:0] addr;
  logic       reg_wr;
  logic       data_wr;
  logic       data_rd;
  logic       timed_out;
  logic       wr_stall;
  logic [7:0] wcnt;
  logic [1:0] irq_en;
  logic       tx_overflow;
  logic       rx_underflow;
  logic [3:0] status;
  logic       unused_ok;

  assign addr      = paddr[3:2];
  assign acc       = psel & penable;
  assign reg_wr    = acc & pwrite;
  assign data_wr   = reg_wr & (addr == A_DATA);
  assign data_rd   = acc & ~pwrite & (addr == A_DATA);
  assign timed_out = data_wr & (wcnt == WCNT_MAX);
  assign wr_stall  = data_wr & ~tx_ready_out & ~timed_out;
  assign status    = {rx_underflow, tx_overflow, tx_ready_out, rx_valid_out};
  assign unused_ok = ^{paddr[1:0], pwdata[31:16]};

  // APB response, FIFO handshakes and read mux; all forced quiet while in reset
  always_comb begin
    tx_data_in  = pwdata[DATA_WIDTH-1:0];
    tx_valid_in = 1'b0;
    rx_ready_in = 1'b0;
    pready      = 1'b1;
    pslverr     = 1'b0;
    prdata      = 32'd0;
    if (!rst) begin
      tx_valid_in = data_wr & ~timed_out;
      rx_ready_in = data_rd & rx_valid_out;
      pready      = ~wr_stall;
      pslverr     = timed_out | (data_rd & ~rx_valid_out);
      if (acc && !pwrite) begin
        case (addr)
          A_DATA:     prdata = rx_valid_out ? 32'(rx_data_out) : 32'd0;
          A_STATUS:   prdata = 32'(status);
          A_PRESCALE: prdata = 32'(prescale);
          default:    prdata = 32'(irq_en);
        endcase
      end
    end
  end

  // Sticky flags let a set win over a same-cycle W1C clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt         <= 8'd0;
      prescale     <= PRESCALE_RESET;
      irq_en       <= 2'd0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      irq          <= 1'b0;
    end else begin
      wcnt <= wr_stall ? wcnt + 8'd1 : 8'd0;
      if (reg_wr && addr == A_PRESCALE) prescale <= pwdata[15:0];
      if (reg_wr && addr == 2'd3)       irq_en   <= pwdata[1:0];
      if (timed_out)
        tx_overflow <= 1'b1;
      else if (reg_wr && addr == A_STATUS && pwdata[2])
        tx_overflow <= 1'b0;
      if (data_rd && !rx_valid_out)
        rx_underflow <= 1'b1;
      else if (reg_wr && addr == A_STATUS && pwdata[3])
        rx_underflow <= 1'b0;
      irq <= |(status[1:0] & irq_en);
    end
  end
endmodule

// File: tb/tb_uart_apb_regs.sv
// Scoreboard bench for uart_apb_regs: APB responses, TX pushes, RX pops and irq timing.
module tb_uart_apb_regs;
  localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_PRESCALE = 2'd2, R_IRQ_EN = 2'd3;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cyc;
  } resp_t;

  logic        clk, rst, psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data_in;
  logic        tx_valid_in, tx_ready_out;
  logic [7:0]  rx_data_out;
  logic        rx_valid_out, rx_ready_in;
  logic [15:0] prescale;
  logic        irq;

  int total = 0;
  int bad = 0;
  resp_t exp_q[$];
  resp_t act_q[$];
  logic [7:0] exp_tx[$];
  logic [7:0] push_log[$];
  int tv_count = 0;
  int pop_count = 0;

  // RX FIFO model: tests own the write pointer, the pop process owns the read pointer
  logic [7:0] rx_mem [16];
  logic [3:0] rx_wp = 4'd0;
  logic [3:0] rx_rp = 4'd0;
  logic       pop_req;
  assign rx_valid_out = (rx_wp != rx_rp);
  assign rx_data_out  = rx_mem[rx_rp];

  uart_apb_regs dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_data_in(tx_data_in), .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .rx_ready_in(rx_ready_in),
    .prescale(prescale), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (tx_valid_in) tv_count++;
    if (tx_valid_in && tx_ready_out) push_log.push_back(tx_data_in);
    if (rx_ready_in) pop_count++;
  end

  always begin
    @(negedge clk);
    pop_req = rx_ready_in;
    @(posedge clk);
    #1;
    if (pop_req) rx_rp = rx_rp + 4'd1;
  end

  task automatic rx_load(input logic [7:0] b);
    rx_mem[rx_wp] = b;
    rx_wp = rx_wp + 4'd1;
  endtask

  // One APB transfer; rdly >= 0 raises tx_ready_out from access cycle index rdly on
  task automatic xfer(input logic wr, input logic [1:0] ri, input logic [31:0] wd, input int rdly);
    resp_t r;
    bit done;
    r = '0;
    done = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {ri, 2'b00}; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rdly >= 0) tx_ready_out = (n >= rdly);
      @(negedge clk);
      if (pready) begin
        r.rdata = prdata; r.err = pslverr; r.cyc = 8'(n + 1); done = 1'b1;
      end
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL xfer_bound: pready=0 for 100 access cycles, want completion");
      r.cyc = 8'hFF;
    end
    act_q.push_back(r);
  endtask

  task automatic test_reset();
    resp_t e, a;
    rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'hFF;
    tx_ready_out = 1'b1;
    rx_load(8'h77);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({tx_valid_in, pready, pslverr, prdata} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
      bad++;
      $display("FAIL reset_wr_forced: got txv=%b rdy=%b err=%b rd=%h, want 0 1 0 0",
               tx_valid_in, pready, pslverr, prdata);
    end
    @(posedge clk); #1;
    pwrite = 1'b0;
    @(negedge clk);
    total++;
    if ({rx_ready_in, pready, prdata} !== {1'b0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL reset_rd_forced: got rxr=%b rdy=%b rd=%h, want 0 1 0", rx_ready_in, pready, prdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    rx_wp = rx_rp;
    @(negedge clk);
    total++;
    if ({prescale, irq} !== {16'd54, 1'b0}) begin
      bad++;
      $display("FAIL reset_regs: got prescale=%0d irq=%b, want 54 0", prescale, irq);
    end
    @(posedge clk); #1;
    exp_q.push_back('{32'h36, 1'b0, 8'd1}); xfer(1'b0, R_PRESCALE, 32'd0, -1);
    exp_q.push_back('{32'h0, 1'b0, 8'd1});  xfer(1'b0, R_IRQ_EN, 32'd0, -1);
    exp_q.push_back('{32'h2, 1'b0, 8'd1});  xfer(1'b0, R_STATUS, 32'd0, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL reset_read: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                 a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  task automatic test_write_ready();
    resp_t e, a;
    int base = push_log.size();
    int tv0 = tv_count;
    tx_ready_out = 1'b1;
    exp_q.push_back('{32'h0, 1'b0, 8'd1}); exp_tx.push_back(8'hA5); xfer(1'b1, R_DATA, 32'hFFFF_FFA5, 0);
    exp_q.push_back('{32'h0, 1'b0, 8'd1}); exp_tx.push_back(8'h01); xfer(1'b1, R_DATA, 32'h01, 0);
    exp_q.push_back('{32'h0, 1'b0, 8'd1}); exp_tx.push_back(8'h02); xfer(1'b1, R_DATA, 32'h02, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL write_ready: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                 a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
      end
    end
    total++;
    if (tv_count - tv0 != 3) begin
      bad++;
      $display("FAIL write_ready_valid_cycles: got %0d, want 3", tv_count - tv0);
    end
    total++;
    if (push_log.size() - base != exp_tx.size()) begin
      bad++;
      $display("FAIL write_ready_push_count: got %0d, want %0d", push_log.size() - base, exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && base + i < push_log.size(); i++) begin
      total++;
      if (push_log[base + i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL write_ready_byte%0d: got %h, want %h", i, push_log[base + i], exp_tx[i]);
      end
    end
    exp_tx.delete();
  endtask

  task automatic test_write_stall();
    resp_t e, a;
    int base = push_log.size();
    exp_q.push_back('{32'h0, 1'b0, 8'd6});
    exp_tx.push_back(8'h3C);
    xfer(1'b1, R_DATA, 32'h3C, 5);
    e = exp_q.pop_front(); a = act_q.pop_front(); total++;
    if (a !== e) begin
      bad++;
      $display("FAIL write_stall: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
               a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
    end
    total++;
    if (push_log.size() - base != 1 || push_log[base] !== exp_tx[0]) begin
      bad++;
      $display("FAIL write_stall_push: got count=%0d byte=%h, want 1 %h",
               push_log.size() - base, push_log[push_log.size() - 1], exp_tx[0]);
    end
    exp_tx.delete();
  endtask

  task automatic test_timeout();
    resp_t e, a;
    int base = push_log.size();
    exp_q.push_back('{32'h0, 1'b1, 8'd17}); xfer(1'b1, R_DATA, 32'h99, 1000);
    exp_q.push_back('{32'h4, 1'b0, 8'd1});  xfer(1'b0, R_STATUS, 32'd0, -1);
    exp_q.push_back('{32'h0, 1'b0, 8'd1});  xfer(1'b1, R_STATUS, 32'h4, -1);
    exp_q.push_back('{32'h0, 1'b0, 8'd1});  xfer(1'b0, R_STATUS, 32'd0, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL timeout: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                 a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
      end
    end
    total++;
    if (push_log.size() != base) begin
      bad++;
      $display("FAIL timeout_no_push: got %0d pushes, want 0", push_log.size() - base);
    end
    tx_ready_out = 1'b1;
  endtask

  task automatic test_reset_abort();
    resp_t e, a;
    int base;
    exp_q.push_back('{32'h0, 1'b0, 8'd1});    xfer(1'b1, R_PRESCALE, 32'hABCD_1234, -1);
    exp_q.push_back('{32'h1234, 1'b0, 8'd1}); xfer(1'b0, R_PRESCALE, 32'd0, -1);
    @(negedge clk);
    total++;
    if (prescale !== 16'h1234) begin
      bad++;
      $display("FAIL prescale_port: got %h, want 1234", prescale);
    end
    @(posedge clk); #1;
    base = push_log.size();
    tx_ready_out = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 32'h5A;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++;
    if (pready !== 1'b0) begin
      bad++;
      $display("FAIL abort_stalled: got pready=%b, want 0", pready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({pready, tx_valid_in} !== 2'b10) begin
      bad++;
      $display("FAIL abort_in_reset: got rdy=%b txv=%b, want 1 0", pready, tx_valid_in);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_ready_out = 1'b1;
    @(negedge clk);
    total++;
    if (prescale !== 16'd54 || push_log.size() != base) begin
      bad++;
      $display("FAIL abort_state: got prescale=%0d pushes=%0d, want 54 0", prescale, push_log.size() - base);
    end
    @(posedge clk); #1;
    exp_q.push_back('{32'h2, 1'b0, 8'd1}); xfer(1'b0, R_STATUS, 32'd0, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL reset_abort: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                 a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    resp_t e, a;
    int p0 = pop_count;
    tx_ready_out = 1'b1;
    rx_load(8'h11);
    rx_load(8'h22);
    exp_q.push_back('{32'h11, 1'b0, 8'd1}); xfer(1'b0, R_DATA, 32'd0, -1);
    exp_q.push_back('{32'h22, 1'b0, 8'd1}); xfer(1'b0, R_DATA, 32'd0, -1);
    exp_q.push_back('{32'h0, 1'b1, 8'd1});  xfer(1'b0, R_DATA, 32'd0, -1);
    exp_q.push_back('{32'hA, 1'b0, 8'd1});  xfer(1'b0, R_STATUS, 32'd0, -1);
    exp_q.push_back('{32'h0, 1'b0, 8'd1});  xfer(1'b1, R_STATUS, 32'h8, -1);
    exp_q.push_back('{32'h2, 1'b0, 8'd1});  xfer(1'b0, R_STATUS, 32'd0, -1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL rx_back_to_back: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                 a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
      end
    end
    total++;
    if (pop_count - p0 != 2) begin
      bad++;
      $display("FAIL rx_pop_count: got %0d, want 2", pop_count - p0);
    end
  endtask

  task automatic test_irq();
    resp_t e, a;
    tx_ready_out = 1'b0;
    exp_q.push_back('{32'h0, 1'b0, 8'd1}); xfer(1'b1, R_IRQ_EN, 32'hFFFF_FFFD, -1);
    exp_q.push_back('{32'h1, 1'b0, 8'd1}); xfer(1'b0, R_IRQ_EN, 32'd0, -1);
    rx_load(8'h5E);
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_before_rise: got %b, want 0", irq); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b, want 1", irq); end
    @(posedge clk); #1;
    exp_q.push_back('{32'h5E, 1'b0, 8'd1}); xfer(1'b0, R_DATA, 32'd0, -1);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_pop_edge: got %b, want 1", irq); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b, want 0", irq); end
    @(posedge clk); #1;
    tx_ready_out = 1'b1;
    exp_q.push_back('{32'h0, 1'b0, 8'd1}); xfer(1'b1, R_IRQ_EN, 32'h2, -1);
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_ready: got %b, want 1", irq); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL irq_xfer: got rd=%h err=%b cyc=%0d, want rd=%h err=%b cyc=%0d",
                 a.rdata, a.err, a.cyc, e.rdata, e.err, e.cyc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'd0; pwdata = 32'd0;
    tx_ready_out = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write_ready();
    test_write_stall();
    test_timeout();
    test_reset_abort();
    test_back_to_back();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
